multiplier_controller_tainttrack: RTL and testbench

- FSM controller that sequences the taint-tracking shift-add multiplier datapath.
- Directly upstream of that datapath:
  - drives its five control strobes (rsclear, mdld, mrld, rsload, rsshr), each with a matching taint bit;
  - consumes the datapath's multiplierReg and multiplierReg_t outputs to choose add-or-skip per bit.
- Tracks whether its own control flow depends on tainted data and propagates that taint onto every control and status output.

---
 rtl/multiplier_controller_tainttrack_if.sv | 33 +++
 rtl/multiplier_controller_tainttrack.sv | 133 +++++++++++++
 tb/tb_multiplier_controller_tainttrack.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_controller_tainttrack_if.sv
// Control/status bundle between the taint-tracking multiplier controller and
// its environment (requester + shift-add datapath).
//   slave  : controller side (consumes start/multiplierReg, drives strobes/status)
//   master : environment side (drives start/multiplierReg, observes strobes/status)
interface multiplier_controller_tainttrack_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNTW  = $clog2(WIDTH)
);
    logic             start;
    logic             start_t;
    logic [WIDTH-1:0] multiplierReg;
    logic [WIDTH-1:0] multiplierReg_t;
    logic             rsclear, mdld, mrld, rsload, rsshr;
    logic             rsclear_t, mdld_t, mrld_t, rsload_t, rsshr_t;
    logic             busy, busy_t;
    logic             done, done_t;
    logic [CNTW-1:0]  bit_cnt;
    logic             state_t;

    modport slave (
        input  start, start_t, multiplierReg, multiplierReg_t,
        output rsclear, mdld, mrld, rsload, rsshr,
               rsclear_t, mdld_t, mrld_t, rsload_t, rsshr_t,
               busy, busy_t, done, done_t, bit_cnt, state_t
    );

    modport master (
        output start, start_t, multiplierReg, multiplierReg_t,
        input  rsclear, mdld, mrld, rsload, rsshr,
               rsclear_t, mdld_t, mrld_t, rsload_t, rsshr_t,
               busy, busy_t, done, done_t, bit_cnt, state_t
    );
endinterface

// File: rtl/multiplier_controller_tainttrack.sv
// Sequencer for the taint-tracking shift-add multiplier datapath.
// Walks the multiplier bits LSB first (INIT, then TEST/ADD/SHIFT per bit,
// then DONE) and keeps a sticky flag recording whether its control flow has
// ever depended on tainted data; that flag annotates every control output.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - slave modport: start/start_t and multiplierReg/_t in;
//            five strobes, busy, done, their taints, bit_cnt, state_t out
module multiplier_controller_tainttrack #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNTW  = $clog2(WIDTH)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    multiplier_controller_tainttrack_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            taint_q, taint_d;

    logic rsclear_q, mdld_q, mrld_q, rsload_q, rsshr_q, busy_q, done_q;
    logic rsclear_d, mdld_d, mrld_d, rsload_d, rsshr_d, busy_d, done_d;

    // Next state, counter and taint; outputs are decoded from the next state
    // so the registered strobes line up exactly with the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        taint_d = taint_q;

        case (state_q)
            S_IDLE: begin
                // Staying or leaving IDLE both depend on start, so its taint
                // is absorbed even when start is low.
                taint_d = taint_q | bus.start_t;
                if (bus.start) state_d = S_INIT;
            end
            S_INIT: begin
                cnt_d   = '0;
                state_d = S_TEST;
            end
            S_TEST: begin
                taint_d = taint_q | bus.multiplierReg_t[cnt_q];
                state_d = bus.multiplierReg[cnt_q] ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = S_TEST;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rsclear_d = (state_d == S_INIT);
        mdld_d    = (state_d == S_INIT);
        mrld_d    = (state_d == S_INIT);
        rsload_d  = (state_d == S_ADD);
        rsshr_d   = (state_d == S_SHIFT);
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    // State, counter, sticky taint and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            taint_q   <= 1'b0;
            rsclear_q <= 1'b0;
            mdld_q    <= 1'b0;
            mrld_q    <= 1'b0;
            rsload_q  <= 1'b0;
            rsshr_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            taint_q   <= taint_d;
            rsclear_q <= rsclear_d;
            mdld_q    <= mdld_d;
            mrld_q    <= mrld_d;
            rsload_q  <= rsload_d;
            rsshr_q   <= rsshr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.rsclear = rsclear_q;
    assign bus.mdld    = mdld_q;
    assign bus.mrld    = mrld_q;
    assign bus.rsload  = rsload_q;
    assign bus.rsshr   = rsshr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bit_cnt = cnt_q;
    assign bus.state_t = taint_q;

    // Every output carries the control-flow taint, asserted or not.
    assign bus.rsclear_t = taint_q;
    assign bus.mdld_t    = taint_q;
    assign bus.mrld_t    = taint_q;
    assign bus.rsload_t  = taint_q;
    assign bus.rsshr_t   = taint_q;
    assign bus.busy_t    = taint_q;
    assign bus.done_t    = taint_q;

endmodule

// File: tb/tb_multiplier_controller_tainttrack.sv
// Scoreboard bench for multiplier_controller_tainttrack with a small
// behavioural shift-add datapath driven by the controller's strobes.
module tb_multiplier_controller_tainttrack;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNTW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiplier_controller_tainttrack_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    multiplier_controller_tainttrack #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Datapath model: multiplicand, multiplier and running product.
    logic [WIDTH-1:0]   mcand_v  = '0;
    logic [WIDTH-1:0]   mplier_v = '0;
    logic [WIDTH-1:0]   mrt_v    = '0;
    logic [WIDTH-1:0]   md       = '0;
    logic [WIDTH-1:0]   mr       = '0;
    logic [2*WIDTH:0]   acc      = '0;

    always @(posedge clk) begin
        if (bus.rsclear) acc <= '0;
        if (bus.mdld)    md  <= mcand_v;
        if (bus.mrld)    mr  <= mplier_v;
        if (bus.rsload)  acc[2*WIDTH:WIDTH] <= {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, md};
        if (bus.rsshr)   acc <= acc >> 1;
    end

    assign bus.multiplierReg   = mr;
    assign bus.multiplierReg_t = mrt_v;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    string exp_seq_q[$];
    string exp_tnt_q[$];
    int    exp_prod_q[$];

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    // Monitor: records strobe/taint letters per busy cycle, scores on done.
    string seq = "";
    string tnt = "";
    always @(negedge clk) begin
        logic [6:0] tv;
        string c;
        string tc;
        string es, et;
        int    ep;
        if (!rst_n) begin
            seq = "";
            tnt = "";
        end else if (bus.busy) begin
            if (bus.done)                                c = "D";
            else if (bus.rsload)                         c = "A";
            else if (bus.rsshr)                          c = "S";
            else if (bus.rsclear && bus.mdld && bus.mrld) c = "I";
            else                                         c = "T";
            tv = {bus.rsclear_t, bus.mdld_t, bus.mrld_t, bus.rsload_t,
                  bus.rsshr_t, bus.busy_t, bus.done_t};
            if (tv == 7'h7f)      tc = "1";
            else if (tv == 7'h00) tc = "0";
            else                  tc = "x";
            seq = {seq, c};
            tnt = {tnt, tc};
            if (bus.done) begin
                n_done++;
                if (exp_seq_q.size() == 0) begin
                    check_int("unexpected_done", 1, 0);
                end else begin
                    es = exp_seq_q.pop_front();
                    et = exp_tnt_q.pop_front();
                    ep = exp_prod_q.pop_front();
                    check_str("strobe_seq", seq, es);
                    check_str("taint_seq", tnt, et);
                    check_int("product", int'(acc[2*WIDTH-1:0]), ep);
                end
                seq = "";
                tnt = "";
            end
        end else begin
            check_int("idle_quiet",
                      int'({bus.rsclear, bus.mdld, bus.mrld, bus.rsload, bus.rsshr, bus.done}), 0);
        end
    end

    task automatic push_exp(input string es, input string et, input int ep);
        exp_seq_q.push_back(es);
        exp_tnt_q.push_back(et);
        exp_prod_q.push_back(ep);
    endtask

    task automatic issue(input int mcand, input int mplier, input int mt);
        @(negedge clk);
        mcand_v     = WIDTH'(mcand);
        mplier_v    = WIDTH'(mplier);
        mrt_v       = WIDTH'(mt);
        bus.start   = 1'b1;
        bus.start_t = 1'b0;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        for (k = 0; k < 100; k++) begin
            if (n_done >= target) break;
            @(negedge clk);
        end
        if (n_done < target) check_int("done_timeout", n_done, target);
    endtask

    task automatic check_all_zero(input string tag);
        check_int({tag, "_strobes"},
                  int'({bus.rsclear, bus.mdld, bus.mrld, bus.rsload, bus.rsshr}), 0);
        check_int({tag, "_busy_done"}, int'({bus.busy, bus.done}), 0);
        check_int({tag, "_taints"},
                  int'({bus.rsclear_t, bus.mdld_t, bus.mrld_t, bus.rsload_t,
                        bus.rsshr_t, bus.busy_t, bus.done_t}), 0);
        check_int({tag, "_bit_cnt"}, int'(bus.bit_cnt), 0);
        check_int({tag, "_state_t"}, int'(bus.state_t), 0);
    endtask

    initial begin
        int k;
        bus.start   = 1'b0;
        bus.start_t = 1'b0;

        #3;
        check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Untainted 0b1011 x 3: done in cycle 13
        push_exp("ITASTASTSTASD", "0000000000000", 33);
        issue(3, 4'b1011, 0);
        wait_done(1);

        // Multiplier 0: no ADD, done in cycle 10
        push_exp("ITSTSTSTSD", "0000000000", 0);
        issue(9, 0, 0);
        wait_done(2);

        // Tainted bit 2 of 0b0100: taint rises entering ADD of bit 2
        push_exp("ITSTSTASTSD", "00000011111", 20);
        issue(5, 4'b0100, 4'b0100);
        wait_done(3);
        check_int("state_t_sticky_bit", int'(bus.state_t), 1);

        // Reset during ADD: outputs clear asynchronously, then normal operation
        issue(3, 4'b1011, 0);
        for (k = 0; k < 50; k++) begin
            if (bus.rsload) break;
            @(negedge clk);
        end
        check_int("reached_add", int'(bus.rsload), 1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_rst");
        push_exp("ITASTASTSTASD", "0000000000000", 33);
        issue(3, 4'b1011, 0);
        wait_done(4);

        // start pulsed during TEST and SHIFT is ignored
        push_exp("ITSTASTASTSD", "000000000000", 42);
        issue(7, 4'b0110, 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(5);
        for (k = 0; k < 20; k++) @(negedge clk);
        check_int("busy_after_ignored", int'(bus.busy), 0);

        // start held high: back-to-back operations via one IDLE cycle
        push_exp("ITASTASTSTSD", "000000000000", 6);
        push_exp("ITASTASTSTSD", "000000000000", 6);
        @(negedge clk);
        mcand_v   = WIDTH'(2);
        mplier_v  = WIDTH'(4'b0011);
        mrt_v     = '0;
        bus.start = 1'b1;
        wait_done(7);
        bus.start = 1'b0;
        for (k = 0; k < 20; k++) @(negedge clk);

        // Tainted start while idle with start low
        check_int("state_t_clean", int'(bus.state_t), 0);
        bus.start_t = 1'b1;
        @(negedge clk);
        bus.start_t = 1'b0;
        check_int("state_t_from_start", int'(bus.state_t), 1);
        push_exp("ITASTASTSTASD", "1111111111111", 33);
        issue(3, 4'b1011, 0);
        wait_done(8);
        for (k = 0; k < 5; k++) @(negedge clk);
        check_int("state_t_persist", int'(bus.state_t), 1);
        check_int("busy_t_idle", int'(bus.busy_t), 1);
        rst_n = 1'b0;
        #1 check_all_zero("taint_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_int("state_t_after_rst", int'(bus.state_t), 0);

        check_int("scoreboard_empty", exp_seq_q.size(), 0);
        check_int("done_total", n_done, 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
